char_anim_fsm: RTL and testbench

CHAR_ANIM_FSM -- requirements
Module: char_anim_fsm

---
 rtl/char_anim_pkg.sv | 24 ++
 rtl/char_anim_fsm_tick.sv | 21 ++
 rtl/char_anim_fsm.sv | 107 ++++++++++
 tb/tb_char_anim_fsm.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_anim_pkg.sv
// Shared state encoding and default animation tables for the character animation FSM.
package char_anim_pkg;

  localparam int ANIM_NUM_STATES = 7;

  typedef enum logic [2:0] {
    ST_STAND   = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_MOVEL   = 3'd2,
    ST_MOVER   = 3'd3,
    ST_DEFENSE = 3'd4,
    ST_HURT    = 3'd5,
    ST_JUMP    = 3'd6
  } anim_state_t;

  // Indexed by state code.
  localparam int DEF_LAST_FRAME [ANIM_NUM_STATES] = '{8, 5, 9, 8, 0, 4, 6};
  localparam int DEF_DELAY      [ANIM_NUM_STATES] = '{10, 3, 10, 10, 10, 10, 4};

  function automatic logic is_one_shot(input anim_state_t s);
    return (s == ST_ATTACK) || (s == ST_DEFENSE) || (s == ST_HURT) || (s == ST_JUMP);
  endfunction

endpackage

// File: rtl/char_anim_fsm_tick.sv
// Rising-edge detector for the animation tick; one registered pulse per frame_clk rise.
module frame_tick_det (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic frame_clk_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_d <= 1'b0;
      tick        <= 1'b0;
    end else begin
      frame_clk_d <= frame_clk;
      tick        <= frame_clk & ~frame_clk_d;
    end
  end

endmodule

// File: rtl/char_anim_fsm.sv
// Character animation state machine: frame sequencing per state, command priority, one-shot exits.
// Optional macro CHAR_ANIM_HURT_PREEMPT_EN lets cmd_hurt interrupt ATTACK/DEFENSE/JUMP.
module char_anim_fsm
  import char_anim_pkg::*;
#(
  parameter int FRAME_W = 8,
  parameter int DELAY_W = 8,
  parameter logic [FRAME_W-1:0] LAST_FRAME [ANIM_NUM_STATES] = '{
    FRAME_W'(DEF_LAST_FRAME[0]), FRAME_W'(DEF_LAST_FRAME[1]), FRAME_W'(DEF_LAST_FRAME[2]),
    FRAME_W'(DEF_LAST_FRAME[3]), FRAME_W'(DEF_LAST_FRAME[4]), FRAME_W'(DEF_LAST_FRAME[5]),
    FRAME_W'(DEF_LAST_FRAME[6])},
  parameter logic [DELAY_W-1:0] DELAY [ANIM_NUM_STATES] = '{
    DELAY_W'(DEF_DELAY[0]), DELAY_W'(DEF_DELAY[1]), DELAY_W'(DEF_DELAY[2]),
    DELAY_W'(DEF_DELAY[3]), DELAY_W'(DEF_DELAY[4]), DELAY_W'(DEF_DELAY[5]),
    DELAY_W'(DEF_DELAY[6])}
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               cmd_attack,
  input  logic               cmd_move_r,
  input  logic               cmd_move_l,
  input  logic               cmd_defense,
  input  logic               cmd_hurt,
  input  logic               cmd_jump,
  output logic [2:0]         state_out,
  output logic [FRAME_W-1:0] frame_num,
  output logic               anim_done,
  output logic               busy
);

  logic               tick;
  logic               preempt;
  anim_state_t        state;
  anim_state_t        target;
  logic [DELAY_W-1:0] delay;
  logic [DELAY_W-1:0] cur_delay;
  logic [FRAME_W-1:0] cur_last;

  frame_tick_det u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign cur_delay = DELAY[state];
  assign cur_last  = LAST_FRAME[state];
  assign state_out = state;

`ifdef CHAR_ANIM_HURT_PREEMPT_EN
  assign preempt = cmd_hurt && (state != ST_HURT);
`else
  assign preempt = 1'b0;
`endif

  // Both move commands together cancel out to no movement.
  always_comb begin
    target = ST_STAND;
    if (cmd_hurt)                       target = ST_HURT;
    else if (cmd_attack)                target = ST_ATTACK;
    else if (cmd_defense)               target = ST_DEFENSE;
    else if (cmd_jump)                  target = ST_JUMP;
    else if (cmd_move_r && !cmd_move_l) target = ST_MOVER;
    else if (cmd_move_l && !cmd_move_r) target = ST_MOVEL;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_STAND;
      delay     <= '0;
      frame_num <= '0;
      anim_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      anim_done <= 1'b0;
      if (tick) begin
        if (!is_one_shot(state) && (target != state)) begin
          state     <= target;
          delay     <= '0;
          frame_num <= '0;
          busy      <= is_one_shot(target);
        end else if (is_one_shot(state) && preempt) begin
          state     <= ST_HURT;
          delay     <= '0;
          frame_num <= '0;
          busy      <= 1'b1;
        end else if (delay < cur_delay) begin
          delay <= delay + 1'b1;
        end else begin
          delay <= '0;
          if (frame_num < cur_last) begin
            frame_num <= frame_num + 1'b1;
          end else begin
            frame_num <= '0;
            if (is_one_shot(state)) begin
              state     <= ST_STAND;
              busy      <= 1'b0;
              anim_done <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_char_anim_fsm.sv
// Self-checking bench for char_anim_fsm: hand vectors, directed corner sequences, random vs. model.
module tb_char_anim_fsm;

  typedef struct packed {
    logic atk, mr, ml, def, hurt, jmp;
  } cmd_t;

  typedef struct {
    cmd_t c;
    int   st;
    int   fr;
    int   bz;
  } vec_t;

`ifdef CHAR_ANIM_HURT_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       cmd_attack = 1'b0, cmd_move_r = 1'b0, cmd_move_l = 1'b0;
  logic       cmd_defense = 1'b0, cmd_hurt = 1'b0, cmd_jump = 1'b0;
  logic [2:0] state_out;
  logic [7:0] frame_num;
  logic       anim_done;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_done = 0;

  // Reference model: state code, frame and per-frame tick count
  int m_state, m_frame, m_delay;
  int LF [7] = '{8, 5, 9, 8, 0, 4, 6};
  int DL [7] = '{10, 3, 10, 10, 10, 10, 4};

  char_anim_fsm dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .cmd_attack(cmd_attack), .cmd_move_r(cmd_move_r), .cmd_move_l(cmd_move_l),
    .cmd_defense(cmd_defense), .cmd_hurt(cmd_hurt), .cmd_jump(cmd_jump),
    .state_out(state_out), .frame_num(frame_num), .anim_done(anim_done), .busy(busy)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (anim_done === 1'b1) done_cnt++;

  function automatic cmd_t mk(input bit atk, mr, ml, def, hurt, jmp);
    cmd_t c;
    c.atk = atk; c.mr = mr; c.ml = ml; c.def = def; c.hurt = hurt; c.jmp = jmp;
    return c;
  endfunction

  function automatic bit one_shot(input int s);
    return (s == 1) || (s == 4) || (s == 5) || (s == 6);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_tick(input cmd_t c, output bit done);
    int tgt;
    bit moved;
    done = 0;
    moved = 0;
    if (!one_shot(m_state)) begin
      if (c.hurt) tgt = 5;
      else if (c.atk) tgt = 1;
      else if (c.def) tgt = 4;
      else if (c.jmp) tgt = 6;
      else if (c.mr && !c.ml) tgt = 3;
      else if (c.ml && !c.mr) tgt = 2;
      else tgt = 0;
      if (tgt != m_state) begin
        m_state = tgt; m_frame = 0; m_delay = 0; moved = 1;
      end
    end else if (PREEMPT && c.hurt && m_state != 5) begin
      m_state = 5; m_frame = 0; m_delay = 0; moved = 1;
    end
    if (!moved) begin
      if (m_delay < DL[m_state]) m_delay++;
      else begin
        m_delay = 0;
        if (m_frame < LF[m_state]) m_frame++;
        else begin
          m_frame = 0;
          if (one_shot(m_state)) begin
            m_state = 0;
            done = 1;
          end
        end
      end
    end
  endtask

  task automatic set_cmds(input cmd_t c);
    cmd_attack = c.atk; cmd_move_r = c.mr; cmd_move_l = c.ml;
    cmd_defense = c.def; cmd_hurt = c.hurt; cmd_jump = c.jmp;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    set_cmds('0);
    frame_clk = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    m_state = 0; m_frame = 0; m_delay = 0;
    exp_done = done_cnt;
  endtask

  task automatic apply_tick(input cmd_t c);
    bit d;
    set_cmds(c);
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    set_cmds('0);
    model_tick(c, d);
    if (d) exp_done++;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".state"}, int'(state_out), m_state);
    check({tag, ".frame"}, int'(frame_num), m_frame);
    check({tag, ".busy"}, int'(busy), int'(one_shot(m_state)));
    check({tag, ".done"}, done_cnt, exp_done);
  endtask

  initial begin
    vec_t vecs [8];
    int   base;
    int   prev;
    bit   wrap_seen;

    vecs[0] = '{mk(0,1,1,0,0,0), 0, 0, 0};
    vecs[1] = '{mk(0,1,0,0,0,0), 3, 0, 0};
    vecs[2] = '{mk(0,1,0,0,0,0), 3, 0, 0};
    vecs[3] = '{mk(0,1,1,0,0,0), 0, 0, 0};
    vecs[4] = '{mk(0,0,1,0,0,0), 2, 0, 0};
    vecs[5] = '{mk(0,0,0,0,0,0), 0, 0, 0};
    vecs[6] = '{mk(0,0,0,1,0,1), 4, 0, 1};
    vecs[7] = '{mk(1,0,0,0,0,0), 4, 0, 1};

    // Reset state
    do_reset();
    check("rst.state", int'(state_out), 0);
    check("rst.frame", int'(frame_num), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(anim_done), 0);

    // Idle: frame advances on the 11th tick
    for (int i = 1; i <= 20; i++) begin
      apply_tick('0);
      cmp_model("idle");
      if (i == 10) check("idle.frame10", int'(frame_num), 0);
      if (i == 11) check("idle.frame11", int'(frame_num), 1);
    end
    check("idle.end_state", int'(state_out), 0);
    check("idle.end_busy", int'(busy), 0);

    // Hand-written vectors
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply_tick(vecs[i].c);
      check($sformatf("vec%0d.state", i), int'(state_out), vecs[i].st);
      check($sformatf("vec%0d.frame", i), int'(frame_num), vecs[i].fr);
      check($sformatf("vec%0d.busy", i), int'(busy), vecs[i].bz);
    end
    // DEFENSE has a single frame of 11 ticks; one tick already elapsed
    base = done_cnt;
    repeat (9) apply_tick('0);
    check("def.still", int'(state_out), 4);
    apply_tick('0);
    check("def.exit_state", int'(state_out), 0);
    check("def.exit_done", done_cnt - base, 1);
    apply_tick(mk(1,0,0,0,1,0));
    check("atkhurt.state", int'(state_out), 5);
    check("atkhurt.busy", int'(busy), 1);

    // Attack one-shot: 6 frames x 4 ticks
    do_reset();
    base = done_cnt;
    apply_tick(mk(1,0,0,0,0,0));
    check("atk.enter_state", int'(state_out), 1);
    check("atk.enter_frame", int'(frame_num), 0);
    repeat (23) apply_tick('0);
    check("atk.t23_state", int'(state_out), 1);
    check("atk.t23_frame", int'(frame_num), 5);
    check("atk.t23_done", done_cnt - base, 0);
    apply_tick('0);
    check("atk.t24_state", int'(state_out), 0);
    check("atk.t24_busy", int'(busy), 0);
    check("atk.t24_done", done_cnt - base, 1);
    repeat (3) apply_tick('0);
    check("atk.done_once", done_cnt - base, 1);

    // Hold move right for 110 ticks, then release
    do_reset();
    wrap_seen = 0;
    prev = 0;
    for (int i = 1; i <= 110; i++) begin
      apply_tick(mk(0,1,0,0,0,0));
      cmp_model("mover");
      if (prev > 0 && frame_num == 0) wrap_seen = 1;
      prev = int'(frame_num);
    end
    check("mover.state", int'(state_out), 3);
    check("mover.wrap", int'(wrap_seen), 1);
    apply_tick('0);
    check("mover.release", int'(state_out), 0);

    // Hurt during attack frame 2
    do_reset();
    base = done_cnt;
    apply_tick(mk(1,0,0,0,0,0));
    repeat (8) apply_tick('0);
    check("pre.frame2", int'(frame_num), 2);
    apply_tick(mk(0,0,0,0,1,0));
    if (PREEMPT) begin
      check("pre.hurt_state", int'(state_out), 5);
      check("pre.hurt_frame", int'(frame_num), 0);
      check("pre.hurt_done", done_cnt - base, 0);
    end else begin
      check("pre.keep_state", int'(state_out), 1);
      check("pre.keep_frame", int'(frame_num), 2);
      repeat (15) apply_tick('0);
      check("pre.finish_state", int'(state_out), 0);
      check("pre.finish_done", done_cnt - base, 1);
    end
    cmp_model("pre");

    // Reset mid-JUMP with a tick in flight
    do_reset();
    apply_tick(mk(0,0,0,0,0,1));
    repeat (15) apply_tick('0);
    check("jump.frame3", int'(frame_num), 3);
    check("jump.state", int'(state_out), 6);
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    check("jrst.state", int'(state_out), 0);
    check("jrst.frame", int'(frame_num), 0);
    check("jrst.busy", int'(busy), 0);
    Reset = 1'b0;
    m_state = 0; m_frame = 0; m_delay = 0;
    repeat (3) @(negedge Clk);
    exp_done = done_cnt;
    check("jrst.settle_frame", int'(frame_num), 0);

    // frame_clk held high 50 cycles counts as one tick
    frame_clk = 1'b1;
    repeat (50) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    begin
      bit d;
      model_tick('0, d);
    end
    repeat (9) apply_tick('0);
    check("hold.frame_9", int'(frame_num), 0);
    apply_tick('0);
    check("hold.frame_10", int'(frame_num), 1);
    cmp_model("hold");

    // Random commands against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cmd_t c;
      c.atk  = ($urandom_range(0, 7) == 0);
      c.mr   = ($urandom_range(0, 2) == 0);
      c.ml   = ($urandom_range(0, 2) == 0);
      c.def  = ($urandom_range(0, 9) == 0);
      c.hurt = ($urandom_range(0, 11) == 0);
      c.jmp  = ($urandom_range(0, 9) == 0);
      apply_tick(c);
      cmp_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
